// File: rtl/hilo_muldiv_seq.sv
// rtl/hilo_muldiv_seq.sv - multicycle mul/div sequencer with HI/LO result capture
module hilo_muldiv_seq #(
    parameter int DIV_SETTLE = 4,
    parameter int MUL_SETTLE = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        op_div,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic [63:0] mul_p,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter load values: the capture happens on the edge where the counter reads zero.
    localparam logic [3:0] DIV_LOAD = 4'(DIV_SETTLE - 1);
    localparam logic [3:0] MUL_LOAD = 4'(MUL_SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_div_q, op_div_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        div_zero_q, div_zero_d;
    logic        capture;

    // Next-state: start acceptance, settle countdown, result capture and mthi/mtlo writes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_div_d   = op_div_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        capture    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    op_a_d     = in_a;
                    op_b_d     = in_b;
                    op_div_d   = op_div;
                    cnt_d      = op_div ? DIV_LOAD : MUL_LOAD;
                    div_zero_d = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Direct writes apply in any state, but a coincident capture overrides them.
        if (hi_wr) hi_d = wr_data;
        if (lo_wr) lo_d = wr_data;

        if (capture) begin
            if (op_div_q) begin
                lo_d       = div_q;
                hi_d       = div_r;
                div_zero_d = (op_b_q == 32'd0);
            end else begin
                lo_d = mul_p[31:0];
                hi_d = mul_p[63:32];
            end
        end

        done_d = capture;
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            op_div_q   <= 1'b0;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_div_q   <= op_div_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// tb/tb_hilo_muldiv_seq.sv - randomized and directed checks of hilo_muldiv_seq against a cycle-count model
module tb_hilo_muldiv_seq;

    localparam int DS = 4;
    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] op_a, op_b;
    logic [31:0] div_q, div_r;
    logic [63:0] mul_p;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hilo_muldiv_seq #(.DIV_SETTLE(DS), .MUL_SETTLE(MS)) dut (
        .clk(clk), .clr(clr), .start(start), .op_div(op_div),
        .in_a(in_a), .in_b(in_b), .op_a(op_a), .op_b(op_b),
        .div_q(div_q), .div_r(div_r), .mul_p(mul_p),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    // Signed divide as the external divider computes it: {remainder, quotient}.
    function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
    endfunction

    function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    assign {div_r, div_q} = div_res(op_a, op_b);
    assign mul_p          = mul_res(op_a, op_b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation accepted at edge k finishes at edge k+SETTLE.
    int          m_cyc;
    int          m_end;
    logic        m_busy, m_done, m_dz, m_div;
    logic [31:0] m_opa, m_opb, m_hi, m_lo;

    always @(posedge clk or posedge clr) begin : model
        logic        cap;
        logic [63:0] res;
        if (clr) begin
            m_cyc  <= 0;
            m_end  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_div  <= 1'b0;
            m_opa  <= '0;
            m_opb  <= '0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            cap = m_busy && (m_cyc + 1 == m_end);
            res = m_div ? div_res(m_opa, m_opb) : mul_res(m_opa, m_opb);
            m_cyc  <= m_cyc + 1;
            m_done <= cap;
            if (hi_wr) m_hi <= wr_data;
            if (lo_wr) m_lo <= wr_data;
            if (cap) begin
                m_hi   <= res[63:32];
                m_lo   <= res[31:0];
                m_busy <= 1'b0;
                if (m_div) m_dz <= (m_opb == 32'd0);
            end
            if (!m_busy && start) begin
                m_opa  <= in_a;
                m_opb  <= in_b;
                m_div  <= op_div;
                m_busy <= 1'b1;
                m_dz   <= 1'b0;
                m_end  <= m_cyc + 1 + (op_div ? DS : MS);
            end
        end
    end

    // Every cycle: all outputs against the model.
    always @(negedge clk) begin
        chk("op_a", {32'd0, op_a}, {32'd0, m_opa});
        chk("op_b", {32'd0, op_b}, {32'd0, m_opb});
        chk("busy", {63'd0, busy}, {63'd0, m_busy});
        chk("done", {63'd0, done}, {63'd0, m_done});
        chk("div_zero", {63'd0, div_zero}, {63'd0, m_dz});
        chk("hi", {32'd0, hi}, {32'd0, m_hi});
        chk("lo", {32'd0, lo}, {32'd0, m_lo});
    end

    task automatic drive_start(input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op_div = d;
        in_a   = a;
        in_b   = b;
    endtask

    // Issue one operation and measure cycles after the start edge until done, and busy cycles.
    task automatic run_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                          output int n, output int bcnt);
        drive_start(d, a, b);
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        bcnt  = int'(busy);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            bcnt += int'(busy);
        end
    endtask

    initial begin : stim
        int n, bcnt, dcnt;
        #2 clr = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_ops", {op_a, op_b}, 64'd0);
        chk("rst_flags", {62'd0, done, div_zero}, 64'd0);
        #10 clr = 1'b0;

        // 100 / 7 with a latency measurement.
        run_op(1'b1, 32'd100, 32'd7, n, bcnt);
        chk("div_done_cycle", 64'(n), 64'(DS + 1));
        chk("div_busy_cycles", 64'(bcnt), 64'(DS));
        chk("div_busy_at_done", {63'd0, busy}, 64'd0);
        chk("div_lo", {32'd0, lo}, 64'd14);
        chk("div_hi", {32'd0, hi}, 64'd2);
        chk("div_dz", {63'd0, div_zero}, 64'd0);

        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, n, bcnt);
        chk("negdiv_lo", {32'd0, lo}, 64'hFFFF_FFF2);
        chk("negdiv_hi", {32'd0, hi}, 64'hFFFF_FFFE);

        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, n, bcnt);
        chk("mul_done_cycle", 64'(n), 64'(MS + 1));
        chk("mul_hilo", {hi, lo}, 64'h0000_0001_0000_0000);

        run_op(1'b1, 32'd5, 32'd0, n, bcnt);
        chk("dz_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("dz_flag", {63'd0, div_zero}, 64'd1);
        drive_start(1'b0, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b0;
        chk("dz_cleared", {63'd0, div_zero}, 64'd0);
        repeat (3) @(negedge clk);

        // Start held high through busy with changed operands, then through the done cycle.
        drive_start(1'b1, 32'd50, 32'd6);
        @(negedge clk);
        in_a = 32'd999;
        in_b = 32'd10;
        n = 1;
        while (!done && n < 40) begin
            chk("hold_op_a", {32'd0, op_a}, 64'd50);
            @(negedge clk);
            n++;
        end
        chk("hold_lo", {32'd0, lo}, 64'd8);
        chk("hold_hi", {32'd0, hi}, 64'd2);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        chk("b2b_op_a", {32'd0, op_a}, 64'd999);
        repeat (DS + 1) @(negedge clk);
        chk("b2b_lo", {32'd0, lo}, 64'd99);

        // mthi in IDLE.
        hi_wr   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_wr = 1'b0;
        chk("mthi_hi", {32'd0, hi}, 64'hDEAD_BEEF);
        chk("mthi_lo", {32'd0, lo}, 64'd99);

        // mtlo colliding with a multiply capture edge.
        drive_start(1'b0, 32'd3, 32'd5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        lo_wr   = 1'b1;
        wr_data = 32'h1234_5678;
        @(negedge clk);
        lo_wr = 1'b0;
        chk("mtlo_collide_done", {63'd0, done}, 64'd1);
        chk("mtlo_collide_lo", {32'd0, lo}, 64'd15);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 2) == 0);
            op_div  = $urandom_range(0, 1) == 1;
            in_a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            in_b    = ($urandom_range(0, 7) == 0) ? 32'd0 :
                      ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            hi_wr   = ($urandom_range(0, 9) == 0);
            lo_wr   = ($urandom_range(0, 9) == 0);
            wr_data = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        repeat (DS + 2) @(negedge clk);

        // Reset in the middle of a divide.
        drive_start(1'b1, 32'd77, 32'd3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        #2 clr = 1'b0;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        chk("midrst_no_done", 64'(dcnt), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
